// File: rtl/mic_frame_fifo.sv
// rtl/mic_frame_fifo.sv - I2S stereo frame capture into a FWFT FIFO with overflow tracking
//
// Captures {left, right} on every falling edge of ws (end of the right word)
// and buffers the frames in a first-word-fall-through FIFO read over a
// valid/ready handshake. Frames arriving while full (and not being popped)
// are dropped, setting a sticky overflow flag and a saturating drop counter.
//
// Optional build macro: MIC_FRAME_PEAK_EN adds per-channel peak-magnitude
// tracking (peak_clear, peak_left, peak_right).
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   enable                gates frame capture (draining is always allowed)
//   ws, left, right       I2S word select and deserialised channel words
//   out_data/out_valid/out_ready   head frame and handshake
//   level                 number of stored frames (0..2^ADDR_W)
//   overflow, drop_count  sticky drop flag and saturating drop counter
//   clear_ovf             synchronous clear of overflow and drop_count
//   peak_clear, peak_left, peak_right   (MIC_FRAME_PEAK_EN only)

module mic_frame_fifo #(
    parameter int ADDR_W = 3,
    parameter int DROP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              ws,
    input  logic [15:0]       left,
    input  logic [15:0]       right,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
`ifdef MIC_FRAME_PEAK_EN
    input  logic              peak_clear,
    output logic [15:0]       peak_left,
    output logic [15:0]       peak_right,
`endif
    input  logic              clear_ovf
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_next;
    logic              ws_d;
    logic              frame_event;
    logic              push_req;
    logic              pop;
    logic              full;
    logic              push;
    logic              drop;
    logic [ADDR_W:0]   level_after_pop;
    logic [ADDR_W:0]   level_next;
    logic [31:0]       frame;

    assign frame_event     = ws_d & ~ws;
    assign push_req        = frame_event & enable;
    assign pop             = out_valid & out_ready;
    assign full            = (level == (ADDR_W + 1)'(DEPTH));
    // A pop in the same cycle frees the slot the new frame lands in.
    assign push            = push_req & (~full | pop);
    assign drop            = push_req & full & ~pop;
    assign frame           = {left, right};
    assign rd_ptr_next     = rd_ptr + ADDR_W'(pop);
    assign level_after_pop = level - (ADDR_W + 1)'(pop);
    assign level_next      = level_after_pop + (ADDR_W + 1)'(push);

    // Storage is not reset; only pointers and flags define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= frame;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ws_d       <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            ws_d      <= ws;
            level     <= level_next;
            out_valid <= (level_next != '0);
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_next;
            end
            // Registered head: bypass the incoming frame when it becomes the
            // head, otherwise prefetch the entry the read pointer moves to.
            if (push && level_after_pop == '0) begin
                out_data <= frame;
            end else if (level_after_pop != '0) begin
                out_data <= mem[rd_ptr_next];
            end
            if (clear_ovf) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_W'(1);
                end
            end
        end
    end

`ifdef MIC_FRAME_PEAK_EN
    function automatic logic [15:0] abs16(input logic [15:0] x);
        if (x == 16'h8000) begin
            return 16'h7FFF;
        end else if (x[15]) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

    logic [15:0] abs_left;
    logic [15:0] abs_right;

    assign abs_left  = abs16(left);
    assign abs_right = abs16(right);

    // peak_clear together with a push restarts the peak from that frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            peak_left  <= '0;
            peak_right <= '0;
        end else if (push) begin
            if (peak_clear || abs_left > peak_left) begin
                peak_left <= abs_left;
            end
            if (peak_clear || abs_right > peak_right) begin
                peak_right <= abs_right;
            end
        end else if (peak_clear) begin
            peak_left  <= '0;
            peak_right <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_mic_frame_fifo.sv
// tb/tb_mic_frame_fifo.sv - scoreboard testbench for mic_frame_fifo

module tb_mic_frame_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        ws = 1'b1;
    logic [15:0] left = '0;
    logic [15:0] right = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clear_ovf = 1'b0;
`ifdef MIC_FRAME_PEAK_EN
    logic        peak_clear = 1'b0;
    logic [15:0] peak_left;
    logic [15:0] peak_right;
`endif

    mic_frame_fifo #(.ADDR_W(3), .DROP_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .ws         (ws),
        .left       (left),
        .right      (right),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count),
`ifdef MIC_FRAME_PEAK_EN
        .peak_clear (peak_clear),
        .peak_left  (peak_left),
        .peak_right (peak_right),
`endif
        .clear_ovf  (clear_ovf)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of frames plus drop bookkeeping.
    logic [31:0] exp_q[$];
    int          m_drops   = 0;
    bit          m_ovf     = 1'b0;
    bit          m_prev_ws = 1'b1;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_drops   = 0;
            m_ovf     = 1'b0;
            m_prev_ws = 1'b1;
        end else begin
            bit was_full;
            bit popped;
            was_full = (exp_q.size() == 8);
            popped   = (exp_q.size() > 0) && out_ready;
            if (popped) void'(exp_q.pop_front());
            if (m_prev_ws && !ws && enable) begin
                if (!was_full || popped) begin
                    exp_q.push_back({left, right});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
            if (clear_ovf) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
            m_prev_ws = ws;
        end
    end

    // Monitor: compares the DUT against the model away from the clock edge.
    always @(negedge clock) begin
        if (!reset) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check("level", 32'(level), 32'(exp_q.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("drop_count", 32'(drop_count), 32'(m_drops));
            if (exp_q.size() > 0) begin
                check("head_data", out_data, exp_q[0]);
            end else if (out_valid && out_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_when_empty: got out_valid=1, expected out_valid=0 (t=%0t)", $time);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int hi, input int lo);
        left  = l;
        right = r;
        ws    = 1'b1;
        step(hi);
        ws    = 1'b0;
        step(lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        reset  = 1'b0;
        enable = 1'b1;
        step(2);

        // Single frame, one-cycle latency to out_valid
        left  = 16'h1234;
        right = 16'hABCD;
        ws    = 1'b1;
        step(16);
        ws = 1'b0;
        step(1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", out_data, 32'h1234ABCD);
        check("t1_level", 32'(level), 32'd1);
        step(15);
        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;

        // Fill 1..8, then one dropped frame, then drain in order
        for (int i = 1; i <= 8; i++) send_frame(16'h0, 16'(i), 2, 2);
        send_frame(16'h0, 16'd9, 2, 2);
        check("t2_level", 32'(level), 32'd8);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_drop_count", 32'(drop_count), 32'd1);
        out_ready = 1'b1;
        step(10);
        out_ready = 1'b0;
        check("t2_drained_level", 32'(level), 32'd0);
        check("t2_drained_valid", 32'(out_valid), 32'd0);
        clear_ovf = 1'b1;
        step(1);
        clear_ovf = 1'b0;

        // Full FIFO with a pop on the exact event cycle
        for (int i = 0; i < 8; i++) send_frame(16'h0, 16'(16'h10 + i), 2, 2);
        left  = 16'h0;
        right = 16'h00EE;
        ws    = 1'b1;
        step(2);
        ws        = 1'b0;
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(1);
        check("t3_level", 32'(level), 32'd8);
        check("t3_drop_count", 32'(drop_count), 32'd0);
        check("t3_overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        step(10);
        out_ready = 1'b0;

        // 300 drops saturate the counter, then clear
        for (int i = 0; i < 8; i++) send_frame(16'(i), 16'(i), 1, 1);
        for (int i = 0; i < 300; i++) send_frame(16'(i), 16'(~i), 1, 1);
        check("t4_drop_sat", 32'(drop_count), 32'd255);
        check("t4_overflow", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        step(1);
        clear_ovf = 1'b0;
        check("t4_clr_overflow", 32'(overflow), 32'd0);
        check("t4_clr_drop", 32'(drop_count), 32'd0);
        out_ready = 1'b1;
        step(10);
        out_ready = 1'b0;

        // Disabled capture, then asynchronous reset mid-stream
        enable = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(16'h5555, 16'(i), 2, 2);
        check("t5_dis_level", 32'(level), 32'd0);
        check("t5_dis_drop", 32'(drop_count), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(16'h7777, 16'(i), 2, 2);
        check("t5_level3", 32'(level), 32'd3);
        ws    = 1'b1;
        reset = 1'b1;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_level", 32'(level), 32'd0);
        step(2);
        reset = 1'b0;
        step(2);

`ifdef MIC_FRAME_PEAK_EN
        peak_clear = 1'b1;
        step(1);
        peak_clear = 1'b0;
        out_ready  = 1'b1;
        send_frame(16'h0100, 16'h0, 2, 2);
        send_frame(16'hF000, 16'h0, 2, 2);
        send_frame(16'h8000, 16'h0, 2, 2);
        check("peak_left", 32'(peak_left), 32'h7FFF);
        check("peak_right", 32'(peak_right), 32'h0);
        peak_clear = 1'b1;
        step(1);
        peak_clear = 1'b0;
        check("peak_cleared", 32'(peak_left), 32'h0);
        out_ready = 1'b0;
        ws        = 1'b1;
        step(2);
`endif

        // Randomised traffic against the model
        repeat (1500) begin
            if ($urandom_range(0, 3) == 0) ws = ~ws;
            if (ws) right = 16'($urandom);
            else    left  = 16'($urandom);
            out_ready = ($urandom_range(0, 3) == 0);
            enable    = ($urandom_range(0, 15) != 0);
            clear_ovf = ($urandom_range(0, 63) == 0);
            step(1);
        end
        clear_ovf = 1'b0;
        out_ready = 1'b1;
        ws        = 1'b1;
        step(12);
        out_ready = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
